// File: rtl/qlearn_pkg.sv
// Shared types and constants for the Q-learning episode scheduler.
package qlearn_pkg;

  localparam int unsigned S_W       = 6;
  localparam int unsigned A_W       = 2;
  localparam int unsigned N_STATES  = 64;
  localparam int unsigned N_ACTIONS = 4;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // One step of the 16-bit Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/qlearn_episode_sched_inflight_scoreboard.sv
// In-order FIFO of in-flight update states with a two-port parallel match.
module inflight_scoreboard
  import qlearn_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [S_W-1:0]   push_state_i,
  input  logic             pop_i,
  input  logic [S_W-1:0]   q0_i,
  input  logic [S_W-1:0]   q1_i,
  output logic             match_c_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [S_W-1:0]   ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign count_o = cnt_q;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= '0;
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        ent_q[wr_q] <= push_state_i;
        vld_q[wr_q] <= 1'b1;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) begin
        vld_q[rd_q] <= 1'b0;
        rd_q        <= ptr_inc(rd_q);
      end
      case ({push_i, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Registered entries only: a same-cycle retire still blocks.
  always_comb begin
    match_c_o = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (vld_q[i] && ((ent_q[i] == q0_i) || (ent_q[i] == q1_i))) match_c_o = 1'b1;
    end
  end

endmodule

// File: rtl/qlearn_episode_sched.sv
// Episode scheduler: epsilon-greedy action issue with RAW hazard stall and drain.
module qlearn_episode_sched
  import qlearn_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = 4,
  parameter int unsigned MAX_STEPS  = 256,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [15:0]    num_episodes,
  input  logic [S_W-1:0] start_state,
  input  logic [S_W-1:0] goal_state,
  input  logic [7:0]     eps,
  input  logic [A_W-1:0] greedy_act,
  input  logic [S_W-1:0] next_state,
  input  logic           pipe_ready,
  input  logic           wb_valid,
  output logic           issue_valid,
  output logic [S_W-1:0] issue_state,
  output logic [A_W-1:0] issue_action,
  output logic [S_W-1:0] issue_next_state,
  output logic           busy,
  output logic           done,
  output logic [15:0]    episode_cnt,
  output logic [8:0]     step_cnt,
  output logic           wb_err
);

  localparam int unsigned CNT_W = $clog2(PIPE_DEPTH + 1);

  sched_state_e     state_q, state_d;
  logic [S_W-1:0]   cur_state_q, cur_state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      episode_cnt_q, episode_cnt_d;
  logic [8:0]       step_cnt_q, step_cnt_d;
  logic             wb_err_q, wb_err_d;

  logic             run, fire, ep_end, last_ep, start_go;
  logic             sb_match, sb_full, sb_empty;
  logic [CNT_W-1:0] sb_count;

  inflight_scoreboard #(.DEPTH(PIPE_DEPTH)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .push_i       (fire),
    .push_state_i (cur_state_q),
    .pop_i        (wb_valid),
    .q0_i         (cur_state_q),
    .q1_i         (next_state),
    .match_c_o    (sb_match),
    .count_o      (sb_count),
    .full_o       (sb_full),
    .empty_o      (sb_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) state_d = (num_episodes == 16'd0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (fire && ep_end && last_ep) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (sb_empty || ((sb_count == CNT_W'(1)) && wb_valid)) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run              = (state_q == ST_RUN);
    issue_valid      = run & ~sb_match & ~sb_full;
    fire             = issue_valid & pipe_ready;
    issue_action     = '0;
    issue_next_state = '0;
    if (run) begin
      issue_action     = (lfsr_q[7:0] < eps) ? lfsr_q[9:8] : greedy_act;
      issue_next_state = next_state;
    end
    busy = run | (state_q == ST_DRAIN);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    start_go      = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start
                    && (num_episodes != 16'd0);
    ep_end        = (next_state == goal_state) || (step_cnt_q == 9'(MAX_STEPS - 1));
    last_ep       = ((episode_cnt_q + 16'd1) == num_episodes);
    cur_state_d   = cur_state_q;
    lfsr_d        = lfsr_q;
    episode_cnt_d = episode_cnt_q;
    step_cnt_d    = step_cnt_q;
    wb_err_d      = wb_err_q;
    if (start_go) begin
      cur_state_d   = start_state;
      episode_cnt_d = '0;
      step_cnt_d    = '0;
      wb_err_d      = 1'b0;
    end
    if (fire) begin
      lfsr_d = lfsr_next(lfsr_q);
      if (ep_end) begin
        episode_cnt_d = episode_cnt_q + 16'd1;
        step_cnt_d    = '0;
        cur_state_d   = start_state;
      end else begin
        step_cnt_d    = step_cnt_q + 9'd1;
        cur_state_d   = next_state;
      end
    end
    // Spurious retire is sticky and wins over a same-cycle start clear.
    if (wb_valid && sb_empty) wb_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state_q   <= '0;
      lfsr_q        <= LFSR_SEED;
      episode_cnt_q <= '0;
      step_cnt_q    <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      cur_state_q   <= cur_state_d;
      lfsr_q        <= lfsr_d;
      episode_cnt_q <= episode_cnt_d;
      step_cnt_q    <= step_cnt_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign issue_state = cur_state_q;
  assign episode_cnt = episode_cnt_q;
  assign step_cnt    = step_cnt_q;
  assign wb_err      = wb_err_q;

endmodule
